// File: rtl/cu_pkg.sv
// ---------------------------------------------------------------------------
// cu_pkg
// Shared types and constants for the multi-cycle RV32I control unit.
//   state_e    : control FSM states
//   alu_op_e   : ALU operation select encoding
//   imm_src_e  : immediate-format select encoding
//   op_class_e : instruction class derived from the opcode field
// Also holds the legal opcode values, writeback/fault codes and the opcode
// classifier used by the top level in DECODE.
// ---------------------------------------------------------------------------
package cu_pkg;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_FAULT  = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_SLTU  = 4'd6,
    ALU_SLL   = 4'd7,
    ALU_SRL   = 4'd8,
    ALU_SRA   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_src_e;

  typedef enum logic [2:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_R       = 3'd1,
    CLS_I       = 3'd2,
    CLS_LOAD    = 3'd3,
    CLS_STORE   = 3'd4,
    CLS_BRANCH  = 3'd5,
    CLS_JAL     = 3'd6,
    CLS_LUI     = 3'd7
  } op_class_e;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MEM = 2'd1;
  localparam logic [1:0] RES_PC4 = 2'd2;

  localparam logic [1:0] FAULT_NONE    = 2'd0;
  localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
  localparam logic [1:0] FAULT_TIMEOUT = 2'd2;

  // Anything outside the supported subset classifies as illegal.
  function automatic op_class_e classify_opcode(input logic [6:0] opc);
    op_class_e cls;
    case (opc)
      OPC_R:      cls = CLS_R;
      OPC_I:      cls = CLS_I;
      OPC_LOAD:   cls = CLS_LOAD;
      OPC_STORE:  cls = CLS_STORE;
      OPC_BRANCH: cls = CLS_BRANCH;
      OPC_JAL:    cls = CLS_JAL;
      OPC_LUI:    cls = CLS_LUI;
      default:    cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder
// Combinational ALU operation select.
//   op_class : instruction class latched in DECODE
//   funct3   : instr[14:12] latched in DECODE
//   funct7b5 : instr[30] latched in DECODE
//   alu_op   : ALU operation for the EXEC cycle
// ---------------------------------------------------------------------------
module alu_decoder
  import cu_pkg::*;
(
  input  op_class_e  op_class,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output alu_op_e    alu_op
);

  // For I-type, instr[30] is part of the immediate, so it only selects SUB
  // for R-type; for shifts it distinguishes SRA/SRAI from SRL/SRLI.
  always_comb begin
    alu_op = ALU_ADD;
    case (op_class)
      CLS_R, CLS_I: begin
        case (funct3)
          3'b000:  alu_op = (op_class == CLS_R && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_op = ALU_SLL;
          3'b010:  alu_op = ALU_SLT;
          3'b011:  alu_op = ALU_SLTU;
          3'b100:  alu_op = ALU_XOR;
          3'b101:  alu_op = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
      end
      CLS_BRANCH: alu_op = ALU_SUB;
      CLS_LUI:    alu_op = ALU_PASSB;
      default:    alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit
// Multi-cycle FSM control unit for the RV32I core (FETCH/DECODE/EXEC/MEM/WB)
// with a stalling memory handshake, wait timeout and sticky fault state.
// Inputs : clk, rst_n (async, active low), opcode/funct3/funct7b5 from the
//          IR, EQ/LT/LTU ALU compare flags, mem_ready.
// Outputs: mem_req/MemWrite memory strobes, IRWrite, PCWrite/PCsrc,
//          RegWrite, ALUsrc/ALUctrl/ImmSrc, ResultSrc, instr_retire pulse,
//          fault/fault_code.
// ---------------------------------------------------------------------------
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int OP_WIDTH      = 7,
  parameter int ALUCTRL_WIDTH = 4,
  parameter int IMMSRC_WIDTH  = 3,
  parameter int MAX_WAIT      = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [OP_WIDTH-1:0]      opcode,
  input  logic [2:0]               funct3,
  input  logic                     funct7b5,
  input  logic                     EQ,
  input  logic                     LT,
  input  logic                     LTU,
  input  logic                     mem_ready,
  output logic                     mem_req,
  output logic                     MemWrite,
  output logic                     IRWrite,
  output logic                     PCWrite,
  output logic                     PCsrc,
  output logic                     RegWrite,
  output logic                     ALUsrc,
  output logic [ALUCTRL_WIDTH-1:0] ALUctrl,
  output logic [IMMSRC_WIDTH-1:0]  ImmSrc,
  output logic [1:0]               ResultSrc,
  output logic                     instr_retire,
  output logic                     fault,
  output logic [1:0]               fault_code
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  op_class_e        op_class_q, op_class_d;
  logic [2:0]       funct3_q, funct3_d;
  logic             funct7b5_q, funct7b5_d;
  logic             fault_q, fault_d;
  logic [1:0]       fault_code_q, fault_code_d;

  alu_op_e alu_op;
  logic    mem_phase;
  logic    timeout;
  logic    branch_taken;
  logic    branch_bad;

  // Instruction fields are captured in DECODE so EXEC/MEM/WB outputs depend
  // only on registered state, never on the live IR inputs.
  alu_decoder u_alu_decoder (
    .op_class (op_class_q),
    .funct3   (funct3_q),
    .funct7b5 (funct7b5_q),
    .alu_op   (alu_op)
  );

  assign mem_phase = (state_q == ST_FETCH) || (state_q == ST_MEM);

  // The counter holds the number of stalled cycles already seen, so a
  // ready response in the cycle the count reaches MAX_WAIT still wins.
  assign timeout = mem_phase && !mem_ready && (wait_cnt_q == CNT_W'(MAX_WAIT));

  // funct3[0] inverts the base comparison; 010/011 are not branch encodings.
  always_comb begin
    branch_taken = 1'b0;
    branch_bad   = 1'b0;
    case (funct3_q)
      3'b000:  branch_taken = EQ;
      3'b001:  branch_taken = !EQ;
      3'b100:  branch_taken = LT;
      3'b101:  branch_taken = !LT;
      3'b110:  branch_taken = LTU;
      3'b111:  branch_taken = !LTU;
      default: branch_bad   = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RST;
      wait_cnt_q   <= '0;
      op_class_q   <= CLS_ILLEGAL;
      funct3_q     <= 3'd0;
      funct7b5_q   <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= FAULT_NONE;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      op_class_q   <= op_class_d;
      funct3_q     <= funct3_d;
      funct7b5_q   <= funct7b5_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = '0;
    op_class_d   = op_class_q;
    funct3_d     = funct3_q;
    funct7b5_d   = funct7b5_q;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;

    // Counter is zero unless a memory phase is actively stalling.
    if (mem_phase && !mem_ready && !timeout) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end

    case (state_q)
      ST_RST: state_d = ST_FETCH;

      ST_FETCH: begin
        if (mem_ready) begin
          state_d = ST_DECODE;
        end else if (timeout) begin
          state_d      = ST_FAULT;
          fault_d      = 1'b1;
          fault_code_d = FAULT_TIMEOUT;
        end
      end

      ST_DECODE: begin
        op_class_d = classify_opcode(opcode[6:0]);
        funct3_d   = funct3;
        funct7b5_d = funct7b5;
        if (classify_opcode(opcode[6:0]) == CLS_ILLEGAL) begin
          state_d      = ST_FAULT;
          fault_d      = 1'b1;
          fault_code_d = FAULT_ILLEGAL;
        end else begin
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        case (op_class_q)
          CLS_R, CLS_I, CLS_JAL, CLS_LUI: state_d = ST_WB;
          CLS_LOAD, CLS_STORE:            state_d = ST_MEM;
          CLS_BRANCH: begin
            if (branch_bad) begin
              state_d      = ST_FAULT;
              fault_d      = 1'b1;
              fault_code_d = FAULT_ILLEGAL;
            end else begin
              state_d = ST_FETCH;
            end
          end
          default: begin
            state_d      = ST_FAULT;
            fault_d      = 1'b1;
            fault_code_d = FAULT_ILLEGAL;
          end
        endcase
      end

      ST_MEM: begin
        if (mem_ready) begin
          state_d = (op_class_q == CLS_LOAD) ? ST_WB : ST_FETCH;
        end else if (timeout) begin
          state_d      = ST_FAULT;
          fault_d      = 1'b1;
          fault_code_d = FAULT_TIMEOUT;
        end
      end

      ST_WB:    state_d = ST_FETCH;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_RST;
    endcase
  end

  // Moore decode of the current state; the only live-input terms are the
  // memory-ready qualifiers and the branch flags in EXEC.
  always_comb begin
    mem_req      = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    PCWrite      = 1'b0;
    PCsrc        = 1'b0;
    RegWrite     = 1'b0;
    ALUsrc       = 1'b0;
    ALUctrl      = '0;
    ImmSrc       = '0;
    ResultSrc    = RES_ALU;
    instr_retire = 1'b0;
    fault        = fault_q;
    fault_code   = fault_code_q;

    case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
        end
      end

      ST_EXEC: begin
        ALUctrl = ALUCTRL_WIDTH'(alu_op);
        case (op_class_q)
          CLS_I: begin
            ALUsrc = 1'b1;
            ImmSrc = IMMSRC_WIDTH'(IMM_I);
          end
          CLS_LOAD: begin
            ALUsrc = 1'b1;
            ImmSrc = IMMSRC_WIDTH'(IMM_I);
          end
          CLS_STORE: begin
            ALUsrc = 1'b1;
            ImmSrc = IMMSRC_WIDTH'(IMM_S);
          end
          CLS_BRANCH: begin
            ImmSrc = IMMSRC_WIDTH'(IMM_B);
            if (!branch_bad) begin
              PCWrite      = branch_taken;
              PCsrc        = branch_taken;
              instr_retire = 1'b1;
            end
          end
          CLS_JAL: begin
            PCWrite = 1'b1;
            PCsrc   = 1'b1;
            ImmSrc  = IMMSRC_WIDTH'(IMM_J);
          end
          CLS_LUI: begin
            ALUsrc = 1'b1;
            ImmSrc = IMMSRC_WIDTH'(IMM_U);
          end
          default: ;
        endcase
      end

      ST_MEM: begin
        mem_req  = 1'b1;
        MemWrite = (op_class_q == CLS_STORE);
        if (mem_ready && op_class_q == CLS_STORE) begin
          instr_retire = 1'b1;
        end
      end

      ST_WB: begin
        RegWrite     = 1'b1;
        instr_retire = 1'b1;
        case (op_class_q)
          CLS_LOAD: ResultSrc = RES_MEM;
          CLS_JAL:  ResultSrc = RES_PC4;
          default:  ResultSrc = RES_ALU;
        endcase
      end

      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_unit
// Builds a cycle-by-cycle expected trace per instruction from the
// instruction class, chosen memory wait counts and the flags driven in each
// cycle, then replays the trace against the control unit.
// ---------------------------------------------------------------------------
module tb_multicycle_control_unit;

  localparam int MAX_WAIT = 15;

  // Bench-side instruction classes; index into opc_of for legal ones.
  localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_BR = 4, C_JAL = 5, C_LUI = 6, C_ILL = 7;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5, EQ, LT, LTU, mem_ready;
  logic       mem_req, MemWrite, IRWrite, PCWrite, PCsrc, RegWrite, ALUsrc;
  logic [3:0] ALUctrl;
  logic [2:0] ImmSrc;
  logic [1:0] ResultSrc;
  logic       instr_retire, fault;
  logic [1:0] fault_code;

  multicycle_control_unit dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .EQ(EQ), .LT(LT), .LTU(LTU), .mem_ready(mem_ready), .mem_req(mem_req),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCsrc(PCsrc),
    .RegWrite(RegWrite), .ALUsrc(ALUsrc), .ALUctrl(ALUctrl), .ImmSrc(ImmSrc),
    .ResultSrc(ResultSrc), .instr_retire(instr_retire), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       rst_n, mem_ready, eq, lt, ltu;
    bit [6:0] opc;
    bit [2:0] f3;
    bit       f7;
    bit       mem_req, mem_write, ir_write, pc_write, pc_src, reg_write, alu_src, retire, fault;
    bit [3:0] alu_ctrl;
    bit [2:0] imm_src;
    bit [1:0] res_src, fcode;
    bit       c_pc_src, c_alu_src, c_alu_ctrl, c_imm, c_res;
  } vec_t;

  vec_t vq[$];
  vec_t tq[$];

  bit [6:0] opc_of [7] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                           7'b1100011, 7'b1101111, 7'b0110111};
  // ALU op by funct3 when instr[30] does not modify it: ADD SLL SLT SLTU XOR SRL OR AND
  bit [3:0] alu_by_f3 [8] = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};

  bit [6:0] cur_opc;
  bit [2:0] cur_f3;
  bit       cur_f7;
  bit       force_on, forced_eq;
  bit       trace_faulted;
  int       vectors = 0;
  int       miscompares = 0;
  int       cycle_idx = 0;

  function automatic bit [3:0] alu_ref(int cls, bit [2:0] f3, bit f7);
    if (cls == C_LUI) return 4'd10;
    if (cls == C_LD || cls == C_ST) return 4'd0;
    if (f3 == 3'd0 && cls == C_R && f7) return 4'd1;
    if (f3 == 3'd5 && f7) return 4'd9;
    return alu_by_f3[f3];
  endfunction

  function automatic bit branch_ref(bit [2:0] f3, bit eq, bit lt, bit ltu);
    bit [1:0] kind;
    bit       base;
    kind = f3[2:1];
    base = (kind == 2'b00) ? eq : (kind == 2'b10) ? lt : ltu;
    return base ^ f3[0];
  endfunction

  function automatic vec_t blank();
    vec_t v;
    v = '{default: 0};
    v.rst_n     = 1'b1;
    v.mem_ready = 1'($urandom);
    v.eq        = force_on ? forced_eq : 1'($urandom);
    v.lt        = 1'($urandom);
    v.ltu       = 1'($urandom);
    v.opc       = cur_opc;
    v.f3        = cur_f3;
    v.f7        = cur_f7;
    return v;
  endfunction

  function automatic vec_t blank_all_care();
    vec_t v;
    v = blank();
    v.c_pc_src = 1; v.c_alu_src = 1; v.c_alu_ctrl = 1; v.c_imm = 1; v.c_res = 1;
    return v;
  endfunction

  task automatic add_fault(input bit [1:0] code);
    vec_t v;
    for (int k = 0; k < 3; k++) begin
      v = blank();
      v.fault = 1'b1;
      v.fcode = code;
      tq.push_back(v);
    end
    trace_faulted = 1'b1;
  endtask

  task automatic add_reset();
    vec_t v;
    v = blank_all_care();
    v.rst_n = 1'b0;
    vq.push_back(v);
    v = blank_all_care();
    vq.push_back(v);
  endtask

  // Expected trace of one instruction starting in FETCH; fw/mw are the
  // number of stalled cycles before mem_ready for fetch and data access.
  task automatic build_instr(input int cls, input bit [6:0] opc, input bit [2:0] f3,
                             input bit f7, input int fw, input int mw);
    vec_t v;
    bit   taken;
    tq.delete();
    trace_faulted = 1'b0;
    cur_opc = opc; cur_f3 = f3; cur_f7 = f7;
    for (int k = 0; k < ((fw > MAX_WAIT) ? MAX_WAIT + 1 : fw); k++) begin
      v = blank(); v.mem_ready = 0; v.mem_req = 1; tq.push_back(v);
    end
    if (fw > MAX_WAIT) begin add_fault(2'd2); return; end
    v = blank(); v.mem_ready = 1; v.mem_req = 1; v.ir_write = 1; v.pc_write = 1;
    v.pc_src = 0; v.c_pc_src = 1; tq.push_back(v);
    v = blank(); tq.push_back(v);
    if (cls == C_ILL) begin add_fault(2'd1); return; end
    v = blank();
    case (cls)
      C_R:  begin v.c_alu_ctrl = 1; v.alu_ctrl = alu_ref(cls, f3, f7); v.c_alu_src = 1; v.alu_src = 0; end
      C_I:  begin v.c_alu_ctrl = 1; v.alu_ctrl = alu_ref(cls, f3, f7); v.c_alu_src = 1; v.alu_src = 1;
                  v.c_imm = 1; v.imm_src = 3'd0; end
      C_LD: begin v.c_alu_ctrl = 1; v.alu_ctrl = alu_ref(cls, f3, f7); v.c_alu_src = 1; v.alu_src = 1;
                  v.c_imm = 1; v.imm_src = 3'd0; end
      C_ST: begin v.c_alu_ctrl = 1; v.alu_ctrl = alu_ref(cls, f3, f7); v.c_alu_src = 1; v.alu_src = 1;
                  v.c_imm = 1; v.imm_src = 3'd1; end
      C_JAL: begin v.pc_write = 1; v.pc_src = 1; v.c_pc_src = 1; v.c_imm = 1; v.imm_src = 3'd4; end
      C_LUI: begin v.c_alu_ctrl = 1; v.alu_ctrl = alu_ref(cls, f3, f7); v.c_imm = 1; v.imm_src = 3'd3; end
      default: begin
        if (f3 == 3'b010 || f3 == 3'b011) begin
          tq.push_back(v); add_fault(2'd1); return;
        end
        taken = branch_ref(f3, v.eq, v.lt, v.ltu);
        v.pc_write = taken; v.pc_src = 1; v.c_pc_src = taken; v.retire = 1;
        tq.push_back(v);
        return;
      end
    endcase
    tq.push_back(v);
    if (cls == C_LD || cls == C_ST) begin
      for (int k = 0; k < ((mw > MAX_WAIT) ? MAX_WAIT + 1 : mw); k++) begin
        v = blank(); v.mem_ready = 0; v.mem_req = 1; v.mem_write = (cls == C_ST); tq.push_back(v);
      end
      if (mw > MAX_WAIT) begin add_fault(2'd2); return; end
      v = blank(); v.mem_ready = 1; v.mem_req = 1; v.mem_write = (cls == C_ST);
      v.retire = (cls == C_ST); tq.push_back(v);
      if (cls == C_ST) return;
    end
    v = blank(); v.reg_write = 1; v.retire = 1; v.c_res = 1;
    v.res_src = (cls == C_LD) ? 2'd1 : (cls == C_JAL) ? 2'd2 : 2'd0;
    tq.push_back(v);
  endtask

  task automatic commit(input bit with_reset);
    foreach (tq[i]) vq.push_back(tq[i]);
    if (with_reset || trace_faulted) add_reset();
  endtask

  task automatic pin(input string name, input int got, input int expv);
    if (got != expv) begin
      miscompares++;
      $display("[TB] FAIL model_%s: got %0d expected %0d", name, got, expv);
    end
  endtask

  function automatic int pick_wait();
    int r;
    r = $urandom_range(0, 19);
    if (r < 10) return 0;
    if (r < 16) return $urandom_range(1, 4);
    if (r == 16) return MAX_WAIT - 1;
    if (r == 17) return MAX_WAIT;
    if (r == 18) return MAX_WAIT + 1;
    return $urandom_range(0, 2);
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst_n = v.rst_n; mem_ready = v.mem_ready; EQ = v.eq; LT = v.lt; LTU = v.ltu;
    opcode = v.opc; funct3 = v.f3; funct7b5 = v.f7;
  endtask

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] expv);
    if (got !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cycle_idx, got, expv);
    end
  endtask

  task automatic checkOutput(input vec_t v);
    vectors++;
    chk("mem_req", {3'b0, mem_req}, {3'b0, v.mem_req});
    chk("MemWrite", {3'b0, MemWrite}, {3'b0, v.mem_write});
    chk("IRWrite", {3'b0, IRWrite}, {3'b0, v.ir_write});
    chk("PCWrite", {3'b0, PCWrite}, {3'b0, v.pc_write});
    chk("RegWrite", {3'b0, RegWrite}, {3'b0, v.reg_write});
    chk("instr_retire", {3'b0, instr_retire}, {3'b0, v.retire});
    chk("fault", {3'b0, fault}, {3'b0, v.fault});
    chk("fault_code", {2'b0, fault_code}, {2'b0, v.fcode});
    if (v.c_pc_src)   chk("PCsrc", {3'b0, PCsrc}, {3'b0, v.pc_src});
    if (v.c_alu_src)  chk("ALUsrc", {3'b0, ALUsrc}, {3'b0, v.alu_src});
    if (v.c_alu_ctrl) chk("ALUctrl", ALUctrl, v.alu_ctrl);
    if (v.c_imm)      chk("ImmSrc", {1'b0, ImmSrc}, {1'b0, v.imm_src});
    if (v.c_res)      chk("ResultSrc", {2'b0, ResultSrc}, {2'b0, v.res_src});
  endtask

  initial begin
    int cls, cut;
    bit [6:0] opc;
    bit legal;
    rst_n = 1'b1; mem_ready = 0; EQ = 0; LT = 0; LTU = 0; opcode = 0; funct3 = 0; funct7b5 = 0;

    add_reset();

    // addi x,x,imm with zero-wait memory
    build_instr(C_I, 7'b0010011, 3'b000, 1'b0, 0, 0);
    pin("addi_len", tq.size(), 4);
    pin("addi_irwrite", tq[0].ir_write, 1);
    pin("addi_alusrc", tq[2].alu_src, 1);
    pin("addi_aluctrl", tq[2].alu_ctrl, 0);
    pin("addi_wb", {tq[3].reg_write, tq[3].retire}, 3);
    commit(0);

    // bne taken and not taken
    force_on = 1; forced_eq = 0;
    build_instr(C_BR, 7'b1100011, 3'b001, 1'b0, 0, 0);
    pin("bne_len", tq.size(), 3);
    pin("bne_taken", {tq[2].pc_write, tq[2].pc_src, tq[2].retire}, 7);
    commit(0);
    forced_eq = 1;
    build_instr(C_BR, 7'b1100011, 3'b001, 1'b0, 0, 0);
    pin("bne_not_taken", tq[2].pc_write, 0);
    commit(0);
    force_on = 0;

    // load with three stalled MEM cycles
    build_instr(C_LD, 7'b0000011, 3'b010, 1'b0, 0, 3);
    pin("load_len", tq.size(), 8);
    pin("load_wb", {tq[7].res_src, tq[7].reg_write}, 3);
    commit(0);

    // fetch timeout
    build_instr(C_R, 7'b0110011, 3'b000, 1'b0, MAX_WAIT + 1, 0);
    pin("timeout_code", tq[MAX_WAIT + 1].fcode, 2);
    pin("timeout_memreq", tq[MAX_WAIT + 1].mem_req, 0);
    commit(0);

    // fetch answered exactly at the timeout boundary
    build_instr(C_I, 7'b0010011, 3'b110, 1'b0, MAX_WAIT, 0);
    pin("boundary_len", tq.size(), MAX_WAIT + 4);
    commit(0);

    // illegal opcode 0000000
    build_instr(C_ILL, 7'b0000000, 3'b000, 1'b0, 0, 0);
    pin("illegal_code", tq[2].fcode, 1);
    commit(0);

    // reset in the middle of a stalled store
    build_instr(C_ST, 7'b0100011, 3'b010, 1'b0, 0, 5);
    tq = tq[0:4];
    pin("store_mid", {tq[4].mem_write, tq[4].mem_req}, 3);
    commit(1);

    for (int n = 0; n < 180; n++) begin
      cls = $urandom_range(0, 19);
      if (cls < 17) begin
        cls = cls % 7;
        opc = opc_of[cls];
      end else begin
        cls = C_ILL;
        do begin
          opc = 7'($urandom);
          legal = 0;
          foreach (opc_of[i]) if (opc_of[i] == opc) legal = 1;
        end while (legal);
      end
      build_instr(cls, opc, 3'($urandom), 1'($urandom), pick_wait(), pick_wait());
      if (tq.size() > 1 && $urandom_range(0, 11) == 0) begin
        cut = $urandom_range(1, tq.size() - 1);
        tq = tq[0:cut-1];
        commit(1);
      end else begin
        commit(0);
      end
    end

    #1;
    foreach (vq[i]) begin
      cycle_idx = i;
      applyStimulus(vq[i]);
      @(negedge clk);
      checkOutput(vq[i]);
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
